// File: rtl/tipi_regs.sv
// TIPI register block: CPU-side tc/td, Pi-side rc/rd and the serial shift engine.
// Define TIPI_OVERRUN_EN to add the sticky ovr status output.
module tipi_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        cru_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_din,
  output logic        rc_sel,
  output logic        rd_sel,
  output logic        tc_sel,
  output logic        td_sel,
  output logic [7:0]  rc,
  output logic [7:0]  rd,
  output logic [7:0]  tc,
  output logic [7:0]  td,
  input  logic        r_clk,
  input  logic        r_le,
  input  logic        r_rt,
  input  logic        r_dout,
`ifdef TIPI_OVERRUN_EN
  output logic        ovr,
`endif
  output logic        r_din
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Pin order in the synchronizer vectors: {r_clk, r_le, r_rt, r_dout}
  logic [3:0] meta_q, sync_q;
  logic       clk_dly_q, le_dly_q;
  logic       clk_edge, le_edge, rt_s, dout_s;

  logic [7:0] tc_q, tc_d, td_q, td_d, rc_q, rc_d, rd_q, rd_d;
  logic [7:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic       ovr_q, ovr_d;

  assign rc_sel = cru_en && (cpu_addr == 16'h5FF9);
  assign rd_sel = cru_en && (cpu_addr == 16'h5FFB);
  assign tc_sel = cru_en && (cpu_addr == 16'h5FFD);
  assign td_sel = cru_en && (cpu_addr == 16'h5FFF);

  assign clk_edge = sync_q[3] & ~clk_dly_q;
  assign le_edge  = sync_q[2] & ~le_dly_q;
  assign rt_s     = sync_q[1];
  assign dout_s   = sync_q[0];

  always_comb begin
    tc_d        = tc_q;
    td_d        = td_q;
    rc_d        = rc_q;
    rd_d        = rd_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    ovr_d       = ovr_q;

    if (cpu_we && tc_sel) tc_d = cpu_din;
    if (cpu_we && td_sel) td_d = cpu_din;

    // A latch edge takes priority and swallows a coincident shift edge.
    // Reload reads tc_q/td_q, so a same-cycle CPU write is not yet visible.
    if (le_edge) begin
      if (state_q == ST_FULL) begin
        if (rt_s) rc_d = shift_in_q;
        else      rd_d = shift_in_q;
      end
      shift_out_d = rt_s ? tc_q : td_q;
      cnt_d       = 4'd0;
      state_d     = ST_IDLE;
      ovr_d       = 1'b0;
    end else if (clk_edge) begin
      if (state_q != ST_FULL) begin
        shift_in_d  = {shift_in_q[6:0], dout_s};
        shift_out_d = {shift_out_q[6:0], 1'b0};
        cnt_d       = cnt_q + 4'd1;
        state_d     = (cnt_q == 4'd7) ? ST_FULL : ST_SHIFT;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= 4'd0;
      sync_q      <= 4'd0;
      clk_dly_q   <= 1'b0;
      le_dly_q    <= 1'b0;
      tc_q        <= 8'd0;
      td_q        <= 8'd0;
      rc_q        <= 8'd0;
      rd_q        <= 8'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      cnt_q       <= 4'd0;
      state_q     <= ST_IDLE;
      ovr_q       <= 1'b0;
    end else begin
      meta_q      <= {r_clk, r_le, r_rt, r_dout};
      sync_q      <= meta_q;
      clk_dly_q   <= sync_q[3];
      le_dly_q    <= sync_q[2];
      tc_q        <= tc_d;
      td_q        <= td_d;
      rc_q        <= rc_d;
      rd_q        <= rd_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      ovr_q       <= ovr_d;
    end
  end

  assign tc    = tc_q;
  assign td    = td_q;
  assign rc    = rc_q;
  assign rd    = rd_q;
  assign r_din = shift_out_q[7];

`ifdef TIPI_OVERRUN_EN
  assign ovr = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_q;
`endif

endmodule

// File: doc/tipi_regs.md
TIPI_REGS -- requirements
Module: tipi_regs

Interface
REQ-001 SHALL have port clk  in  1  sole system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port cru_en  in  1  TIPI DSR enabled; gates all CPU-side decode.
REQ-004 SHALL have port cpu_addr  in  16  CPU address bus.
REQ-005 SHALL have port cpu_we  in  1  one-clk write strobe.
REQ-006 SHALL have port cpu_din  in  8  CPU write data.
REQ-007 SHALL have ports rc_sel, rd_sel, tc_sel, td_sel  out  1 each  register selects to the downstream read mux.
REQ-008 SHALL have ports rc, rd, tc, td  out  8 each  register contents to the downstream read mux.
REQ-009 SHALL have ports r_clk, r_le, r_rt, r_dout  in  1 each  Pi shift clock, latch enable, register type (1 = control pair, 0 = data pair), Pi-to-FPGA data.
REQ-010 SHALL have port r_din  out  1  FPGA-to-Pi data, equal to shift_out[7].

Function
REQ-011 Selects SHALL be combinational: rc_sel = cru_en & addr==5FF9h; rd_sel = 5FFBh; tc_sel = 5FFDh; td_sel = 5FFFh; at most one SHALL be high.
REQ-012 cpu_we & tc_sel SHALL load tc from cpu_din at that clk edge; the same rule SHALL apply to td_sel and td; writes to rc and rd SHALL be ignored.
REQ-013 r_clk, r_le, r_rt and r_dout SHALL each pass through a 2-flop synchronizer; rising edges of r_clk and r_le SHALL be detected on the synchronized signal with a third flop.
REQ-014 Each detected edge SHALL act on the 3rd clk rising edge after the pin change is first sampled.
REQ-015 State machine: IDLE (cnt=0), SHIFT (1..7), FULL (cnt=8); cnt is 4 bits.
REQ-016 An r_clk edge in IDLE or SHIFT SHALL do: shift_in <= {shift_in[6:0], r_dout_s}; shift_out <= shift_out<<1; cnt+1. Data is MSB first.
REQ-017 An r_clk edge in FULL SHALL leave shift_in, shift_out and cnt unchanged.
REQ-018 An r_le edge in FULL SHALL load shift_in into rc (r_rt_s=1) or rd (r_rt_s=0).
REQ-019 An r_le edge in IDLE or SHIFT SHALL leave rc and rd unchanged.
REQ-020 Every r_le edge SHALL load shift_out from tc (r_rt_s=1) or td (r_rt_s=0), set cnt=0 and enter IDLE.
REQ-021 If r_le and r_clk edges are detected in the same cycle, the r_le edge SHALL win and the r_clk edge SHALL be discarded.
REQ-022 If a CPU write to tc/td and an r_le reload occur in the same cycle, shift_out SHALL take the pre-write register value.

Reset
REQ-023 While reset is high: tc, td, rc, rd, shift_in, shift_out = 00h; cnt = 0; state IDLE; all synchronizer flops = 0; r_din = 0.
REQ-024 Reset mid-transfer SHALL abandon the partial byte; the first r_le edge after reset SHALL NOT commit.
REQ-025 Select outputs SHALL remain combinational during reset.

Configuration
REQ-026 Macro TIPI_OVERRUN_EN SHALL control the overrun status output.
REQ-027 With TIPI_OVERRUN_EN defined: add output ovr (1 bit), set sticky by an r_clk edge in FULL and cleared by an r_le edge or by reset.
REQ-028 Without TIPI_OVERRUN_EN: no ovr port; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then write A5h to 5FFFh with cru_en=1 -> td=A5h, td_sel=1 during the access; rc/rd/tc stay 00h.
REQ-030 r_rt=0, r_le pulse, 8 r_clk pulses with r_dout = 1,1,0,0,0,0,1,1, then r_le -> rd=C3h; r_din sampled before each r_clk = td bits 7..0.
REQ-031 Same sequence with r_rt=1 but only 7 r_clk pulses, then r_le -> rc unchanged; cnt returns to 0.
REQ-032 Ten r_clk pulses then r_le -> first 8 bits committed; ovr=1 after the 9th pulse and 0 after r_le (TIPI_OVERRUN_EN build).
REQ-033 r_le and r_clk rising on the same clk edge in SHIFT -> no shift, cnt=0; write to 5FF9h with cru_en=0 -> no register change, all selects 0.
REQ-034 Reset asserted after 4 shifts, then 4 r_clk pulses and r_le -> rc = rd = 00h.
